// File: rtl/team_08_bcd_score_counter_if.sv
// Score counter bus: game-logic controls in, BCD score digits and status out.
//   master: game logic (drives score_inc/game_over/restart, reads the score)
//   slave : score counter (reads controls, drives digits and status)
interface team_08_bcd_score_counter_if;
   logic       score_inc;
   logic       game_over;
   logic       restart;
   logic [3:0] bcd_ones;
   logic [3:0] bcd_tens;
   logic [3:0] hs_ones;
   logic [3:0] hs_tens;
   logic       at_max;
   logic       running;

   modport master (
      output score_inc, game_over, restart,
      input  bcd_ones, bcd_tens, hs_ones, hs_tens, at_max, running
   );

   modport slave (
      input  score_inc, game_over, restart,
      output bcd_ones, bcd_tens, hs_ones, hs_tens, at_max, running
   );
endinterface

// File: rtl/team_08_bcd_score_counter.sv
// Two-digit BCD score keeper with high-score register and RUN/OVER game FSM.
// Ports:
//   clk    - system clock, all state on posedge
//   reset  - asynchronous active-low reset
//   bus    - slave side of team_08_bcd_score_counter_if:
//            score_inc (each 0->1 = +1 point), game_over, restart in;
//            bcd_ones/bcd_tens (score), hs_ones/hs_tens (high score),
//            at_max (score == MAX_SCORE, combinational), running out.
module team_08_bcd_score_counter #(
   parameter int unsigned MAX_SCORE = 99,
   parameter bit          SATURATE  = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   team_08_bcd_score_counter_if.slave    bus
);

   localparam logic [3:0] MAX_TENS = 4'(MAX_SCORE / 10);
   localparam logic [3:0] MAX_ONES = 4'(MAX_SCORE % 10);

   typedef enum logic {
      RUN  = 1'b0,
      OVER = 1'b1
   } state_t;

   state_t     state;
   logic       inc_q;
   logic       running_q;
   logic [3:0] ones;
   logic [3:0] tens;
   logic [3:0] hs_o;
   logic [3:0] hs_t;

   logic       inc_edge;
   logic       at_max_int;
   logic       beats_hs;
   logic [3:0] nxt_ones;
   logic [3:0] nxt_tens;

   assign inc_edge   = bus.score_inc & ~inc_q;
   assign at_max_int = (tens == MAX_TENS) && (ones == MAX_ONES);
   // Decimal compare: tens digit dominates, ones breaks the tie.
   assign beats_hs   = (tens > hs_t) || ((tens == hs_t) && (ones > hs_o));

   // Incremented score with BCD carry and saturate/wrap at MAX_SCORE.
   always_comb begin
      nxt_ones = ones;
      nxt_tens = tens;
      if (at_max_int) begin
         if (!SATURATE) begin
            nxt_ones = 4'd0;
            nxt_tens = 4'd0;
         end
      end else if (ones == 4'd9) begin
         nxt_ones = 4'd0;
         nxt_tens = tens + 4'd1;
      end else begin
         nxt_ones = ones + 4'd1;
      end
   end

   // Game FSM, score and high-score registers; priority restart > game_over > inc.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         running_q <= 1'b1;
         inc_q     <= 1'b0;
         ones      <= 4'd0;
         tens      <= 4'd0;
         hs_o      <= 4'd0;
         hs_t      <= 4'd0;
      end else begin
         inc_q <= bus.score_inc;
         case (state)
            RUN: begin
               if (bus.restart) begin
                  ones <= 4'd0;
                  tens <= 4'd0;
               end else if (bus.game_over) begin
                  state     <= OVER;
                  running_q <= 1'b0;
                  if (beats_hs) begin
                     hs_o <= ones;
                     hs_t <= tens;
                  end
               end else if (inc_edge) begin
                  ones <= nxt_ones;
                  tens <= nxt_tens;
               end
            end
            OVER: begin
               if (bus.restart) begin
                  state     <= RUN;
                  running_q <= 1'b1;
                  ones      <= 4'd0;
                  tens      <= 4'd0;
               end
            end
            default: begin
               state     <= RUN;
               running_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.bcd_ones = ones;
   assign bus.bcd_tens = tens;
   assign bus.hs_ones  = hs_o;
   assign bus.hs_tens  = hs_t;
   assign bus.at_max   = at_max_int;
   assign bus.running  = running_q;

endmodule

// File: tb/tb_team_08_bcd_score_counter.sv
// Self-checking bench: saturating and wrapping counters (MAX_SCORE=99) driven in
// lockstep and compared every cycle against an integer-arithmetic score model.
module tb_team_08_bcd_score_counter;

   localparam int MAX = 99;

   logic clk;
   logic reset;
   logic score_inc;
   logic game_over;
   logic restart;

   int checks;
   int errors;

   // Reference model: index 0 = saturating, 1 = wrapping.
   int m_score [2];
   int m_hs    [2];
   int m_run   [2];
   int m_prev;

   team_08_bcd_score_counter_if bus_sat ();
   team_08_bcd_score_counter_if bus_wrp ();

   assign bus_sat.score_inc = score_inc;
   assign bus_sat.game_over = game_over;
   assign bus_sat.restart   = restart;
   assign bus_wrp.score_inc = score_inc;
   assign bus_wrp.game_over = game_over;
   assign bus_wrp.restart   = restart;

   team_08_bcd_score_counter #(.MAX_SCORE(99), .SATURATE(1'b1)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_sat.slave)
   );

   team_08_bcd_score_counter #(.MAX_SCORE(99), .SATURATE(1'b0)) dut_wrp (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_wrp.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_score[i] = 0;
         m_hs[i]    = 0;
         m_run[i]   = 1;
      end
      m_prev = 0;
   endtask

   task automatic model_step();
      int edge_seen;
      edge_seen = (score_inc && !m_prev) ? 1 : 0;
      m_prev    = int'(score_inc);
      for (int i = 0; i < 2; i++) begin
         if (m_run[i] == 1) begin
            if (restart) m_score[i] = 0;
            else if (game_over) begin
               if (m_score[i] > m_hs[i]) m_hs[i] = m_score[i];
               m_run[i] = 0;
            end else if (edge_seen == 1) begin
               if (m_score[i] == MAX) m_score[i] = (i == 0) ? MAX : 0;
               else m_score[i] = m_score[i] + 1;
            end
         end else if (restart) begin
            m_score[i] = 0;
            m_run[i]   = 1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".sat.score"}, 10 * int'(bus_sat.bcd_tens) + int'(bus_sat.bcd_ones), m_score[0]);
      check({tag, ".sat.ones"},  int'(bus_sat.bcd_ones), m_score[0] % 10);
      check({tag, ".sat.hs"},    10 * int'(bus_sat.hs_tens) + int'(bus_sat.hs_ones), m_hs[0]);
      check({tag, ".sat.at_max"}, int'(bus_sat.at_max), (m_score[0] == MAX) ? 1 : 0);
      check({tag, ".sat.running"}, int'(bus_sat.running), m_run[0]);
      check({tag, ".wrp.score"}, 10 * int'(bus_wrp.bcd_tens) + int'(bus_wrp.bcd_ones), m_score[1]);
      check({tag, ".wrp.hs"},    10 * int'(bus_wrp.hs_tens) + int'(bus_wrp.hs_ones), m_hs[1]);
      check({tag, ".wrp.at_max"}, int'(bus_wrp.at_max), (m_score[1] == MAX) ? 1 : 0);
      check({tag, ".wrp.running"}, int'(bus_wrp.running), m_run[1]);
   endtask

   // One clock: model follows the edge, outputs sampled 1 time unit later.
   task automatic cycle(input string tag);
      @(posedge clk);
      if (!reset) model_reset();
      else model_step();
      #1;
      check_all(tag);
   endtask

   task automatic pulse(input string tag);
      score_inc = 1'b1;
      cycle(tag);
      score_inc = 1'b0;
      cycle(tag);
   endtask

   task automatic ctrl(input string tag, input logic go, input logic rs, input logic inc);
      game_over = go;
      restart   = rs;
      score_inc = inc;
      cycle(tag);
      game_over = 1'b0;
      restart   = 1'b0;
   endtask

   // Called away from the clock edge; checks the async clear before any edge.
   task automatic async_reset(input string tag);
      reset = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b0;
      score_inc = 1'b0;
      game_over = 1'b0;
      restart   = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      check("reset.running", int'(bus_sat.running), 1);
      reset = 1'b1;

      // 1: five pulses, each visible one cycle after its rising edge.
      for (int i = 0; i < 5; i++) begin
         score_inc = 1'b1;
         cycle("t1");
         check("t1.latency", int'(bus_sat.bcd_ones), i + 1);
         score_inc = 1'b0;
         cycle("t1");
      end
      check("t1.tens", int'(bus_sat.bcd_tens), 0);
      check("t1.ones", int'(bus_sat.bcd_ones), 5);

      // 2: held high counts once.
      score_inc = 1'b1;
      for (int i = 0; i < 20; i++) cycle("t2");
      score_inc = 1'b0;
      cycle("t2");
      check("t2.held", int'(bus_sat.bcd_ones), 6);

      // 3: carries 09->10 and 19->20.
      for (int i = 0; i < 3; i++) pulse("t3");
      check("t3.at09", int'(bus_sat.bcd_ones), 9);
      pulse("t3");
      check("t3.carry10", 10 * int'(bus_sat.bcd_tens) + int'(bus_sat.bcd_ones), 10);
      for (int i = 0; i < 10; i++) pulse("t3");
      check("t3.carry20", 10 * int'(bus_sat.bcd_tens) + int'(bus_sat.bcd_ones), 20);

      // 4: run to 99, then saturate vs wrap.
      while (m_score[0] < MAX && checks < 20000) pulse("t4");
      check("t4.at99", int'(bus_sat.at_max), 1);
      pulse("t4");
      check("t4.sat_hold", 10 * int'(bus_sat.bcd_tens) + int'(bus_sat.bcd_ones), 99);
      check("t4.wrap_zero", 10 * int'(bus_wrp.bcd_tens) + int'(bus_wrp.bcd_ones), 0);
      check("t4.wrap_at_max", int'(bus_wrp.at_max), 0);

      // 5: game over commits high score, frozen in OVER, kept over restart.
      async_reset("t5.rst");
      for (int i = 0; i < 37; i++) pulse("t5");
      ctrl("t5.go", 1'b1, 1'b0, 1'b0);
      check("t5.hs37", 10 * int'(bus_sat.hs_tens) + int'(bus_sat.hs_ones), 37);
      check("t5.over", int'(bus_sat.running), 0);
      for (int i = 0; i < 3; i++) pulse("t5.frozen");
      check("t5.frozen37", 10 * int'(bus_sat.bcd_tens) + int'(bus_sat.bcd_ones), 37);
      ctrl("t5.rs", 1'b0, 1'b1, 1'b0);
      check("t5.run", int'(bus_sat.running), 1);
      for (int i = 0; i < 12; i++) pulse("t5.g2");
      ctrl("t5.go2", 1'b1, 1'b0, 1'b0);
      check("t5.hs_kept", 10 * int'(bus_sat.hs_tens) + int'(bus_sat.hs_ones), 37);

      // 6: coincidences.
      async_reset("t6.rst");
      for (int i = 0; i < 4; i++) pulse("t6");
      ctrl("t6.go_inc", 1'b1, 1'b0, 1'b1);
      score_inc = 1'b0;
      check("t6.score04", 10 * int'(bus_sat.bcd_tens) + int'(bus_sat.bcd_ones), 4);
      check("t6.hs04", 10 * int'(bus_sat.hs_tens) + int'(bus_sat.hs_ones), 4);
      ctrl("t6.rs_go_over", 1'b1, 1'b1, 1'b0);
      check("t6.run_again", int'(bus_sat.running), 1);
      for (int i = 0; i < 6; i++) pulse("t6");
      ctrl("t6.rs_go_run", 1'b1, 1'b1, 1'b1);
      score_inc = 1'b0;
      check("t6.rs_score", 10 * int'(bus_sat.bcd_tens) + int'(bus_sat.bcd_ones), 0);
      check("t6.rs_hs", 10 * int'(bus_sat.hs_tens) + int'(bus_sat.hs_ones), 4);
      for (int i = 0; i < 3; i++) pulse("t6");
      score_inc = 1'b1;
      async_reset("t6.async");
      cycle("t6.inc_after_reset");
      check("t6.counts_once", int'(bus_sat.bcd_ones), 1);
      score_inc = 1'b0;

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         score_inc = 1'($urandom_range(0, 1));
         game_over = ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0;
         restart   = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
         if ($urandom_range(0, 699) == 0) async_reset("rnd.rst");
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
